// File: rtl/sc_io_display_ctrl.sv
// Memory-mapped seven-segment display and switch controller for the CPU I/O window.
// Channel values are rendered by one shared sequential double-dabble engine.
`timescale 1ns/1ps
module sc_io_display_ctrl #(
  parameter int          NUM_CH    = 3,
  parameter int          CH_DIGITS = 2,
  parameter int          VAL_W     = 7,
  parameter int          SW_W      = 8,
  parameter logic [31:0] IO_BASE   = 32'hffffff00
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  input  logic                         we,
  output logic [31:0]                  rdata,
  input  logic [SW_W-1:0]              sw_in,
  output logic [7*CH_DIGITS*NUM_CH-1:0] hex_out,
  output logic                         busy
);

  localparam int SEG_W = 7 * CH_DIGITS;
  localparam int BW    = 4 * (CH_DIGITS + 1);
  localparam logic [6:0] DASH  = 7'b011_1111;
  localparam logic [6:0] BLANK = 7'b111_1111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < CH_DIGITS + 1; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  logic             hit;
  logic [7:0]       off;
  logic [VAL_W-1:0] val_r  [NUM_CH];
  logic [1:0]       mode_r [NUM_CH];
  logic [NUM_CH-1:0] wr_val, wr_mode, set_vec, clr_vec, pending, req, status;
  logic [2:0]       sel, pick;
  logic [4:0]       cnt;
  logic [SW_W-1:0]  sw_s1, sw_sync;
  logic [31:0]      rd_nxt;
  logic [VAL_W-1:0] cur_val;
  logic [1:0]       cur_mode;

  logic [VAL_W-1:0] val_p0, bin_p0;
  logic [1:0]       mode_p0;
  logic [BW-1:0]    bcd_p0, adj;
  logic             ovf_p0;

  logic [15:0]      val16;
  logic [3:0]       dig;
  logic             ovf, seen;
  logic [SEG_W-1:0] ch_seg;

  assign hit  = (addr[31:8] == IO_BASE[31:8]);
  assign off  = addr[7:0];
  assign req  = pending | set_vec;
  assign busy = (state != IDLE) || (|pending);

  always_comb begin
    wr_val   = '0;
    wr_mode  = '0;
    clr_vec  = '0;
    status   = '0;
    cur_val  = '0;
    cur_mode = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_val[k]  = we && hit && (off == 8'(16*k));
      wr_mode[k] = we && hit && (off == 8'(16*k + 4));
      clr_vec[k] = (state == LOAD) && (sel == 3'(k));
      status[k]  = pending[k] || ((state != IDLE) && (sel == 3'(k)));
      if (sel == 3'(k)) begin
        cur_val  = val_r[k];
        cur_mode = mode_r[k];
      end
    end
    set_vec = wr_val | wr_mode;
  end

  // Lowest-numbered requester wins; an incoming write counts as already pending.
  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[k]) pick = 3'(k);
  end

  always_comb begin
    rd_nxt = '0;
    if (hit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (off == 8'(16*k))     rd_nxt = 32'(val_r[k]);
        if (off == 8'(16*k + 4)) rd_nxt = {30'b0, mode_r[k]};
      end
      for (int j = 0; j < SW_W / 4; j++)
        if (off == 8'(96 + 4*j)) rd_nxt = {28'b0, sw_sync[4*j +: 4]};
      if (off == 8'h70) rd_nxt = 32'(status);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD:    state_nxt = cur_mode[0] ? DONE : SHIFT;
      SHIFT:   if (cnt == 5'(VAL_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        val_r[k]  <= '0;
        mode_r[k] <= '0;
      end
      pending <= '0;
      sw_s1   <= '0;
      sw_sync <= '0;
      rdata   <= '0;
      sel     <= '0;
      cnt     <= '0;
      hex_out <= '1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_val[k])  val_r[k]  <= wdata[VAL_W-1:0];
        if (wr_mode[k]) mode_r[k] <= wdata[1:0];
      end
      pending <= (pending & ~clr_vec) | set_vec;
      sw_s1   <= sw_in;
      sw_sync <= sw_s1;
      rdata   <= rd_nxt;
      if (state == IDLE) sel <= pick;
      if (state == LOAD)       cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + 5'd1;
      for (int k = 0; k < NUM_CH; k++)
        if ((state == DONE) && (sel == 3'(k))) hex_out[SEG_W*k +: SEG_W] <= ch_seg;
    end
  end

  // p0: operand capture at LOAD, then one double-dabble step per SHIFT cycle
  assign adj = dabble_adj(bcd_p0);

  always_ff @(posedge clock) begin
    if (state == LOAD) begin
      val_p0  <= cur_val;
      bin_p0  <= cur_val;
      mode_p0 <= cur_mode;
      bcd_p0  <= '0;
      ovf_p0  <= 1'b0;
    end else if (state == SHIFT) begin
      bcd_p0  <= {adj[BW-2:0], bin_p0[VAL_W-1]};
      bin_p0  <= bin_p0 << 1;
      ovf_p0  <= ovf_p0 | adj[BW-1];
    end
  end

  // Segment rendering, scanned from the top digit down for leading-zero blanking
  always_comb begin
    val16  = 16'(val_p0);
    ovf    = !mode_p0[0] && (ovf_p0 || (bcd_p0[BW-1 -: 4] != 4'd0));
    seen   = 1'b0;
    dig    = '0;
    ch_seg = '1;
    for (int d = CH_DIGITS - 1; d >= 0; d--) begin
      dig = mode_p0[0] ? val16[4*d +: 4] : bcd_p0[4*d +: 4];
      if (dig != 4'd0) seen = 1'b1;
      if (ovf)                                 ch_seg[7*d +: 7] = DASH;
      else if (mode_p0[1] && !seen && d != 0)  ch_seg[7*d +: 7] = BLANK;
      else                                     ch_seg[7*d +: 7] = glyph(dig);
    end
  end

  logic unused;
  assign unused = ^{wdata[31:VAL_W], val16};

endmodule

// File: tb/tb_sc_io_display_ctrl.sv
// Directed bench for sc_io_display_ctrl: register map, conversion latency,
// display encodings, channel arbitration, switch sync and reset behaviour.
`timescale 1ns/1ps
module tb_sc_io_display_ctrl;

  localparam int HW = 42;
  localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000, SA = 7'b0001000, SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;

  logic          clock, reset, we, busy;
  logic [31:0]   addr, wdata, rdata;
  logic [7:0]    sw_in;
  logic [HW-1:0] hex_out;

  int n_tests = 0;
  int n_fail  = 0;

  sc_io_display_ctrl dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sw_in(sw_in), .hex_out(hex_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0; addr = 32'h0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clock);
    addr = a; we = 1'b0;
    @(posedge clock);
    #1;
    chk_eq(tag, rdata, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_eq(tag, busy, 1'b0);
  endtask

  function automatic logic [13:0] ch(input int k);
    return hex_out[14*k +: 14];
  endfunction

  initial begin
    int n;
    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; sw_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_eq("rst_hex", hex_out, {HW{1'b1}});
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_rdata", rdata, 32'h0);
    @(negedge clock) reset = 1'b0;
    read_chk("rd_status0", 32'hffffff70, 32'h0);
    read_chk("rd_val0_0", 32'hffffff00, 32'h0);
    read_chk("rd_sw0", 32'hffffff60, 32'h0);

    // Decimal 42 on ch0: display changes exactly at edge 10
    store(32'hffffff00, 32'd42);
    repeat (8) @(posedge clock);
    #1;
    chk_eq("dec_e9_ch0", ch(0), {SB, SB});
    chk_eq("dec_e9_busy", busy, 1'b1);
    @(posedge clock);
    #1;
    chk_eq("dec_e10_ch0", ch(0), {S4, S2});
    chk_eq("dec_e10_ch1", ch(1), {SB, SB});
    chk_eq("dec_e10_ch2", ch(2), {SB, SB});
    chk_eq("dec_e10_busy", busy, 1'b0);

    // Overflow and leading-zero blanking on ch1
    store(32'hffffff10, 32'd123);
    wait_idle("idle_ovf");
    chk_eq("ovf_ch1", ch(1), {SD, SD});
    store(32'hffffff14, 32'd2);
    store(32'hffffff10, 32'd7);
    wait_idle("idle_lzb");
    chk_eq("lzb_ch1", ch(1), {SB, S7});
    chk_eq("lzb_ch0_kept", ch(0), {S4, S2});

    // Hex mode on ch2: display changes at edge 3
    store(32'hffffff24, 32'd1);
    wait_idle("idle_hexmode");
    chk_eq("hex_zero_ch2", ch(2), {S0, S0});
    store(32'hffffff20, 32'h3C);
    @(posedge clock);
    #1;
    chk_eq("hex_e2_ch2", ch(2), {S0, S0});
    @(posedge clock);
    #1;
    chk_eq("hex_e3_ch2", ch(2), {S3, SC});

    // Arbitration: ch1 busy, then ch2 and ch0 queue; ch0 must go first
    store(32'hffffff10, 32'd5);
    store(32'hffffff20, 32'h5A);
    store(32'hffffff00, 32'd99);
    @(negedge clock) addr = 32'hffffff70;
    n = 0;
    while (ch(0) != {S9, S9} && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_eq("arb_ch0_first", ch(0), {S9, S9});
    chk_eq("arb_ch2_old", ch(2), {S3, SC});
    chk_eq("arb_status_bit2", rdata[2], 1'b1);
    wait_idle("idle_arb");
    chk_eq("arb_ch2_final", ch(2), {S5, SA});
    chk_eq("arb_ch1_final", ch(1), {SB, S5});
    chk_eq("arb_ch0_final", ch(0), {S9, S9});
    read_chk("rd_status_clr", 32'hffffff70, 32'h0);

    // Switches and register readback
    @(negedge clock) sw_in = 8'hA5;
    repeat (2) @(posedge clock);
    read_chk("rd_sw_lo", 32'hffffff60, 32'h5);
    read_chk("rd_sw_hi", 32'hffffff64, 32'hA);
    read_chk("rd_sw_unmapped", 32'hffffff68, 32'h0);
    read_chk("rd_mode1", 32'hffffff14, 32'h2);
    read_chk("rd_mode2", 32'hffffff24, 32'h1);
    read_chk("rd_val0", 32'hffffff00, 32'd99);
    read_chk("rd_val2", 32'hffffff20, 32'h5A);
    read_chk("rd_unmapped", 32'hffffff08, 32'h0);
    read_chk("rd_nohit", 32'h12345600, 32'h0);

    // Ignored writes: non-hit and read-only offsets
    store(32'h12345600, 32'd11);
    chk_eq("nohit_wr_busy", busy, 1'b0);
    store(32'hffffff70, 32'd7);
    chk_eq("ro_wr_busy", busy, 1'b0);
    read_chk("nohit_wr_val0", 32'hffffff00, 32'd99);

    // Reset in the middle of a SHIFT sequence
    store(32'hffffff00, 32'd42);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk_eq("midrst_hex", hex_out, {HW{1'b1}});
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    chk_eq("postrst_hex", hex_out, {HW{1'b1}});
    chk_eq("postrst_busy", busy, 1'b0);
    read_chk("postrst_val0", 32'hffffff00, 32'h0);
    read_chk("postrst_mode1", 32'hffffff14, 32'h0);
    read_chk("postrst_sw", 32'hffffff60, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
